// File: rtl/poisson_spike_gen.sv
// poisson_spike_gen
// ------------------------------------------------------------------------
// Time-multiplexed Poisson spike generator for a neuron array. The array
// controller reads one neuron word from neuron RAM and presents it here
// with poisson_en. The block compares the activity field against a shared
// pseudo-random sample and manages the refractory counter. One clock later
// it returns the updated word for write-back, together with a spike flag.
//
// Handshake: poisson_en is a valid strobe with no back-pressure. Every
// cycle in which poisson_en is high is one evaluation. The result of an
// evaluation sampled at edge N is presented on poisson_out/spike after
// edge N. Evaluations may arrive on consecutive cycles with no bubbles.
//
// Neuron word layout:
//   [ACTIVITY_WIDTH+REFRACTORY_WIDTH-1:REFRACTORY_WIDTH] activity
//   [REFRACTORY_WIDTH-1:0]                               refractory count
//
// Ports:
//   clk          clock, rising edge
//   reset        synchronous, active-high reset (overrides poisson_en)
//   poisson_en   poisson_in valid; evaluate this cycle
//   poisson_in   neuron word read from neuron RAM
//   poisson_out  updated neuron word (registered); holds while idle
//   spike        single-cycle spike pulse, aligned with poisson_out
//   spike_count  16-bit wrapping count of spike pulses
//                (present only when POISSON_SPIKE_CNT_EN is defined)
//
// Optional feature macro: POISSON_SPIKE_CNT_EN
// ------------------------------------------------------------------------
module poisson_spike_gen #(
    parameter int ACTIVITY_WIDTH   = 9,
    parameter int REFRACTORY_WIDTH = 4,
    parameter int REFRACTORY_PER   = 4
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       poisson_en,
    input  logic [ACTIVITY_WIDTH+REFRACTORY_WIDTH-1:0] poisson_in,
    output logic [ACTIVITY_WIDTH+REFRACTORY_WIDTH-1:0] poisson_out,
`ifdef POISSON_SPIKE_CNT_EN
    output logic [15:0]                                spike_count,
`endif
    output logic                                       spike
);

    localparam int NEUR_WIDTH = ACTIVITY_WIDTH + REFRACTORY_WIDTH;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam logic [REFRACTORY_WIDTH-1:0] REF_ONE  = REFRACTORY_WIDTH'(1);
    localparam logic [REFRACTORY_WIDTH-1:0] REF_ZERO = '0;
    localparam logic [REFRACTORY_WIDTH-1:0] REF_LOAD = REFRACTORY_WIDTH'(REFRACTORY_PER);

    logic [15:0]                   lfsr;
    logic [15:0]                   lfsr_next;
    logic [ACTIVITY_WIDTH-1:0]     act;
    logic [REFRACTORY_WIDTH-1:0]   ref_cnt;
    logic [ACTIVITY_WIDTH-1:0]     rnd;
    logic                          spike_next;
    logic [REFRACTORY_WIDTH-1:0]   ref_next;

    assign act     = poisson_in[NEUR_WIDTH-1:REFRACTORY_WIDTH];
    assign ref_cnt = poisson_in[REFRACTORY_WIDTH-1:0];

    // The sample uses the LFSR value before this evaluation's advance.
    assign rnd = lfsr[ACTIVITY_WIDTH-1:0];

    // Galois right-shift step. A maximal-length polynomial never reaches 0
    // from a non-zero seed.
    assign lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);

    always_comb begin
        spike_next = 1'b0;
        ref_next   = REF_ZERO;
        if (ref_cnt != REF_ZERO) begin
            // A refractory neuron is blocked. Larger than REFRACTORY_PER
            // values written externally simply count down.
            ref_next = ref_cnt - REF_ONE;
        end else if (rnd < act) begin
            spike_next = 1'b1;
            ref_next   = REF_LOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr        <= LFSR_SEED;
            poisson_out <= '0;
            spike       <= 1'b0;
        end else if (poisson_en) begin
            lfsr        <= lfsr_next;
            poisson_out <= {act, ref_next};
            spike       <= spike_next;
        end else begin
            // Idle: the last word holds and the spike pulse ends.
            spike <= 1'b0;
        end
    end

`ifdef POISSON_SPIKE_CNT_EN
    // Counts each cycle the registered spike is high. The count therefore
    // lags the spike pulse by one cycle, and it wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            spike_count <= 16'h0000;
        end else if (spike) begin
            spike_count <= spike_count + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_poisson_spike_gen.sv
module tb_poisson_spike_gen;

    localparam int AW = 9;
    localparam int RW = 4;
    localparam int RP = 4;
    localparam int NW = AW + RW;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          poisson_en = 1'b0;
    logic [NW-1:0] poisson_in = '0;
    logic [NW-1:0] poisson_out;
    logic          spike;
`ifdef POISSON_SPIKE_CNT_EN
    logic [15:0]   spike_count;
`endif

    always #5 clk = ~clk;

    poisson_spike_gen #(
        .ACTIVITY_WIDTH(AW),
        .REFRACTORY_WIDTH(RW),
        .REFRACTORY_PER(RP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .poisson_en(poisson_en),
        .poisson_in(poisson_in),
        .poisson_out(poisson_out),
`ifdef POISSON_SPIKE_CNT_EN
        .spike_count(spike_count),
`endif
        .spike(spike)
    );

    // ---------------- scoreboard / reference model ----------------
    int checks = 0;
    int errors = 0;
    logic [NW:0] exp_q[$];          // {spike, word} expected per cycle

    int unsigned   m_lfsr;          // behavioural random source
    logic [NW-1:0] m_hold;          // word the output should be holding
    logic          m_spk_prev;      // expected spike before the next edge
    int unsigned   m_cnt;           // expected spike_count

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Plain-arithmetic model of one evaluation; advances the random source.
    function automatic logic [NW:0] model_eval(input logic [NW-1:0] word);
        int unsigned act;
        int unsigned refc;
        int unsigned r;
        int unsigned nref;
        logic        s;
        act  = int'(word) / (1 << RW);
        refc = int'(word) % (1 << RW);
        r    = m_lfsr % (1 << AW);
        if (refc != 0) begin
            s = 1'b0; nref = refc - 1;
        end else if (r < act) begin
            s = 1'b1; nref = RP;
        end else begin
            s = 1'b0; nref = 0;
        end
        m_lfsr = (m_lfsr / 2) ^ (((m_lfsr % 2) == 1) ? 32'hB400 : 32'h0);
        return {s, NW'(act * (1 << RW) + nref)};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step(input logic en, input logic [NW-1:0] word, input string tag);
        logic [NW:0] e;
        if (en) exp_q.push_back(model_eval(word));
        else    exp_q.push_back({1'b0, m_hold});
        poisson_en = en;
        poisson_in = word;
        @(posedge clk);
        #1;
        m_cnt = (m_cnt + (m_spk_prev ? 1 : 0)) % 65536;
        e = exp_q.pop_front();
        check({tag, "_word"}, 32'(poisson_out), 32'(e[NW-1:0]));
        check({tag, "_spike"}, 32'(spike), 32'(e[NW]));
`ifdef POISSON_SPIKE_CNT_EN
        check({tag, "_count"}, 32'(spike_count), m_cnt);
`endif
        m_hold     = e[NW-1:0];
        m_spk_prev = e[NW];
    endtask

    task automatic do_reset(input logic en, input logic [NW-1:0] word);
        reset      = 1'b1;
        poisson_en = en;
        poisson_in = word;
        @(posedge clk);
        #1;
        reset      = 1'b0;
        m_lfsr     = 32'hACE1;
        m_hold     = '0;
        m_spk_prev = 1'b0;
        m_cnt      = 0;
        check("reset_word", 32'(poisson_out), 32'h0);
        check("reset_spike", 32'(spike), 32'h0);
`ifdef POISSON_SPIKE_CNT_EN
        check("reset_count", 32'(spike_count), 32'h0);
`endif
    endtask

    function automatic logic [NW-1:0] mk(input int unsigned act, input int unsigned refc);
        return NW'(act * (1 << RW) + refc);
    endfunction

    // ---------------- directed/randomized sequence ----------------
    initial begin
        int nspk;
        logic [NW-1:0] w;

        @(posedge clk);
        do_reset(1'b0, '0);

        // First evaluation after reset: r = 0x0E1 < 511 spikes.
        step(1'b1, mk(511, 0), "first");
        check("first_word_const", 32'(poisson_out), 32'h1FF4);
        check("first_spike_const", 32'(spike), 32'h1);

        // Refractory neuron counts down, no spike.
        step(1'b1, mk(511, 3), "refr");
        check("refr_word_const", 32'(poisson_out), 32'h1FF2);

        // Zero activity never spikes.
        nspk = 0;
        for (int i = 0; i < 1000; i++) begin
            step(1'b1, mk(0, 0), "act0");
            if (spike) nspk++;
        end
        check("act0_spikes", 32'(nspk), 32'h0);

        // Write-back loop on one word from refractory 0.
        w = mk(511, 0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, w, "wb");
            w = m_hold;
        end

        // Idle gap: output holds, spike low, random source frozen.
        for (int i = 0; i < 10; i++) step(1'b0, mk($urandom_range(511, 0), 0), "gap");
        step(1'b1, mk(300, 0), "after_gap");

        // Random words, including refractory values above REFRACTORY_PER.
        for (int i = 0; i < 200; i++) begin
            step($urandom_range(3, 0) != 0, mk($urandom_range(511, 0), $urandom_range(15, 0)), "rand");
        end

        // Half probability, refractory rewritten to 0 each time.
        nspk = 0;
        for (int i = 0; i < 4096; i++) begin
            step(1'b1, mk(256, 0), "half");
            if (spike) nspk++;
        end
        check("half_lo", 32'(nspk >= 1898), 32'h1);
        check("half_hi", 32'(nspk <= 2198), 32'h1);

        // Reset in the middle of a stream restarts the sequence.
        do_reset(1'b1, mk(511, 0));
        step(1'b1, mk(511, 0), "restart");
        check("restart_word_const", 32'(poisson_out), 32'h1FF4);
        check("restart_spike_const", 32'(spike), 32'h1);
        for (int i = 0; i < 20; i++) step(1'b1, mk(256, 0), "restart_half");

`ifdef POISSON_SPIKE_CNT_EN
        do_reset(1'b0, '0);
        for (int i = 0; i < 5; i++) step(1'b1, mk(511, 0), "cnt5");
        step(1'b0, '0, "cnt5_idle");
        step(1'b0, '0, "cnt5_idle2");
        begin
            int guard;
            guard = 0;
            while (m_cnt != 3 && guard < 70000) begin
                step(1'b1, mk(511, 0), "wrap");
                guard++;
            end
            check("wrap_reached", 32'(guard < 70000), 32'h1);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
